// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALUop encodings and the
// decoded control bundle carried down the pipeline.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       regdst;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load sitting in ID/EX and the
// instruction currently in ID. Purely combinational.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_alusrc,
    input  logic              id_memwrite,
    input  logic              id_branch,
    output logic              hazard
);

    logic rt_is_read;
    logic rs_match;
    logic rt_match;

    // rt is a source for R-type, store data and branch compare; for
    // immediate forms it is only a destination and cannot conflict.
    assign rt_is_read = !id_alusrc | id_memwrite | id_branch;
    assign rs_match   = (ex_rt == id_rs);
    assign rt_match   = (ex_rt == id_rt) & rt_is_read;

    assign hazard = id_valid & ex_valid & ex_memread & (ex_rt != '0)
                  & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
// Optional BUBBLE_CNT_EN adds a saturating count of inserted bubbles.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_regdst,
    input  logic              id_branch,
    input  logic              id_memread,
    input  logic              id_memtoreg,
    input  logic              id_memwrite,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic [1:0]        id_aluop,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              stall_id,
    output logic              ex_valid,
    output logic              ex_regdst,
    output logic              ex_branch,
    output logic              ex_memread,
    output logic              ex_memtoreg,
    output logic              ex_memwrite,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic [1:0]        ex_aluop,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd
`ifdef BUBBLE_CNT_EN
    ,
    output logic [15:0]       bubble_cnt
`endif
);

    ctrl_t             id_ctrl;
    ctrl_t             ctrl_d,    ctrl_q;
    logic              valid_d,   valid_q;
    logic [DATA_W-1:0] rs_data_d, rs_data_q;
    logic [DATA_W-1:0] rt_data_d, rt_data_q;
    logic [DATA_W-1:0] imm_d,     imm_q;
    logic [DATA_W-1:0] pc4_d,     pc4_q;
    logic [REG_AW-1:0] rs_d,      rs_q;
    logic [REG_AW-1:0] rt_d,      rt_q;
    logic [REG_AW-1:0] rd_d,      rd_q;
    logic [DATA_W-1:0] imm_ext;
    logic              hazard;
    logic              bubble_ins;

    assign id_ctrl = '{regdst:   id_regdst,   branch:   id_branch,
                       memread:  id_memread,  memtoreg: id_memtoreg,
                       memwrite: id_memwrite, alusrc:   id_alusrc,
                       regwrite: id_regwrite, aluop:    id_aluop};

    assign imm_ext = {{(DATA_W-16){id_imm[15]}}, id_imm};

    load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .id_valid    (id_valid),
        .ex_valid    (valid_q),
        .ex_memread  (ctrl_q.memread),
        .ex_rt       (rt_q),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_alusrc   (id_alusrc),
        .id_memwrite (id_memwrite),
        .id_branch   (id_branch),
        .hazard      (hazard)
    );

    // A flush kills the ID instruction, so there is nothing left to hold.
    assign stall_id = (hazard | ex_hold) & !flush;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a variable unassigned and no latch is inferred.
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        pc4_d      = pc4_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        bubble_ins = 1'b0;

        if (flush) begin
            valid_d    = 1'b0;
            ctrl_d     = CTRL_NOP;
            bubble_ins = 1'b1;
        end else if (ex_hold) begin
            // contents frozen by the defaults above
        end else if (hazard) begin
            valid_d    = 1'b0;
            ctrl_d     = CTRL_NOP;
            bubble_ins = 1'b1;
        end else begin
            valid_d   = id_valid;
            ctrl_d    = id_valid ? id_ctrl : CTRL_NOP;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = imm_ext;
            pc4_d     = id_pc4;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_NOP;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            pc4_q     <= pc4_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
        end
    end

`ifdef BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_ins && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble_ins;
`endif

    assign ex_valid    = valid_q;
    assign ex_regdst   = ctrl_q.regdst;
    assign ex_branch   = ctrl_q.branch;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_aluop    = ctrl_q.aluop;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_imm      = imm_q;
    assign ex_pc4      = pc4_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed ID vectors push expected
// stall/EX state; a monitor pops and compares each cycle.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam ctrl_t C_R   = '{regdst:1'b1, branch:1'b0, memread:1'b0, memtoreg:1'b0,
                                memwrite:1'b0, alusrc:1'b0, regwrite:1'b1, aluop:ALUOP_FUNCT};
    localparam ctrl_t C_LW  = '{regdst:1'b0, branch:1'b0, memread:1'b1, memtoreg:1'b1,
                                memwrite:1'b0, alusrc:1'b1, regwrite:1'b1, aluop:ALUOP_ADD};
    localparam ctrl_t C_ADI = '{regdst:1'b0, branch:1'b0, memread:1'b0, memtoreg:1'b0,
                                memwrite:1'b0, alusrc:1'b1, regwrite:1'b1, aluop:ALUOP_ADD};

    typedef struct {
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } id_t;

    typedef struct {
        string       name;
        bit          chk_stall;
        logic        stall;
        bit          chk_data;
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_regdst, id_branch, id_memread, id_memtoreg;
    logic        id_memwrite, id_alusrc, id_regwrite;
    logic [1:0]  id_aluop;
    logic [31:0] id_rs_data, id_rt_data, id_pc4;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush, ex_hold;
    logic        stall_id, ex_valid, ex_regdst, ex_branch, ex_memread, ex_memtoreg;
    logic        ex_memwrite, ex_alusrc, ex_regwrite;
    logic [1:0]  ex_aluop;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
`ifdef BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_regdst(id_regdst), .id_branch(id_branch), .id_memread(id_memread),
        .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
        .id_regwrite(id_regwrite), .id_aluop(id_aluop),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_pc4(id_pc4),
        .flush(flush), .ex_hold(ex_hold), .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_regdst(ex_regdst), .ex_branch(ex_branch), .ex_memread(ex_memread),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
`ifdef BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic id_t mk_id(input logic v, input ctrl_t c, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [31:0] rsd, input logic [31:0] rtd,
                                  input logic [15:0] imm, input logic [31:0] pc4);
        id_t r;
        r.valid = v; r.ctrl = c; r.rs = rs; r.rt = rt; r.rd = rd;
        r.rs_data = rsd; r.rt_data = rtd; r.imm = imm; r.pc4 = pc4;
        return r;
    endfunction

    // Expected EX contents after capturing v; imm32 is the hand-extended immediate.
    function automatic exp_t ex_load(input string n, input logic st, input id_t v,
                                     input logic [31:0] imm32);
        exp_t e;
        e.name = n; e.chk_stall = 1'b1; e.stall = st; e.chk_data = 1'b1;
        e.valid = v.valid; e.ctrl = v.ctrl;
        e.rs_data = v.rs_data; e.rt_data = v.rt_data; e.imm = imm32; e.pc4 = v.pc4;
        e.rs = v.rs; e.rt = v.rt; e.rd = v.rd;
        return e;
    endfunction

    function automatic exp_t ex_bubble(input string n, input logic st);
        exp_t e;
        e = ex_load(n, st, mk_id(1'b0, CTRL_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0),
                    32'd0);
        e.chk_data = 1'b0;
        return e;
    endfunction

    task automatic step(input id_t v, input logic fl, input logic hd, input logic rst,
                        input exp_t e);
        @(posedge clk);
        #1;
        reset       = rst;
        flush       = fl;
        ex_hold     = hd;
        id_valid    = v.valid;
        id_regdst   = v.ctrl.regdst;
        id_branch   = v.ctrl.branch;
        id_memread  = v.ctrl.memread;
        id_memtoreg = v.ctrl.memtoreg;
        id_memwrite = v.ctrl.memwrite;
        id_alusrc   = v.ctrl.alusrc;
        id_regwrite = v.ctrl.regwrite;
        id_aluop    = v.ctrl.aluop;
        id_rs_data  = v.rs_data;
        id_rt_data  = v.rt_data;
        id_imm      = v.imm;
        id_rs       = v.rs;
        id_rt       = v.rt;
        id_rd       = v.rd;
        id_pc4      = v.pc4;
        exp_q.push_back(e);
    endtask

    // Monitor: stall_id is sampled mid-cycle with the new ID inputs, the
    // EX register just after the following edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_stall) check({e.name, " stall_id"}, 256'(stall_id), 256'(e.stall));
                @(posedge clk);
                #2;
                check({e.name, " valid/ctrl"},
                      256'({ex_valid, ex_regdst, ex_branch, ex_memread, ex_memtoreg,
                            ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop}),
                      256'({e.valid, e.ctrl}));
                if (e.chk_data)
                    check({e.name, " data"},
                          256'({ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd}),
                          256'({e.rs_data, e.rt_data, e.imm, e.pc4, e.rs, e.rt, e.rd}));
            end
        end
    end

    initial begin
        id_t  rnd, r_pass, lw8, add8, lw0, r_rs0, addi8, lw_rs8, idle, r_a, r_b, r_c;
        exp_t z;
        int   wait_cyc;

        rnd    = mk_id(1'b1, ctrl_t'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                       $urandom, $urandom, 16'($urandom), $urandom);
        r_pass = mk_id(1'b1, C_R,   5'd1,  5'd2,  5'd3,  32'h5,   32'h7,   16'h8000, 32'h104);
        lw8    = mk_id(1'b1, C_LW,  5'd4,  5'd8,  5'd0,  32'h100, 32'h0,   16'h0010, 32'h108);
        add8   = mk_id(1'b1, C_R,   5'd8,  5'd9,  5'd10, 32'hAA,  32'hBB,  16'h5020, 32'h10C);
        lw0    = mk_id(1'b1, C_LW,  5'd5,  5'd0,  5'd0,  32'h200, 32'h0,   16'hFFFC, 32'h110);
        r_rs0  = mk_id(1'b1, C_R,   5'd0,  5'd6,  5'd7,  32'h0,   32'h66,  16'h3820, 32'h114);
        addi8  = mk_id(1'b1, C_ADI, 5'd3,  5'd8,  5'd0,  32'h33,  32'h88,  16'h0007, 32'h118);
        lw_rs8 = mk_id(1'b1, C_LW,  5'd8,  5'd8,  5'd0,  32'h300, 32'h0,   16'h0004, 32'h11C);
        idle   = mk_id(1'b0, C_LW,  5'd8,  5'd8,  5'd1,  32'h9,   32'h9,   16'h0000, 32'h120);
        r_a    = mk_id(1'b1, C_R,   5'd11, 5'd12, 5'd13, 32'h11,  32'h12,  16'h0001, 32'h124);
        r_b    = mk_id(1'b1, C_R,   5'd13, 5'd11, 5'd12, 32'h13,  32'h14,  16'h0002, 32'h128);
        r_c    = mk_id(1'b1, C_R,   5'd14, 5'd15, 5'd16, 32'hDEAD,32'hBEEF,16'hFFFF, 32'h12C);

        z = ex_load("reset", 1'b0, mk_id(1'b0, CTRL_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0,
                                         16'd0, 32'd0), 32'd0);
        reset = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        {id_valid, id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite,
         id_alusrc, id_regwrite, id_aluop} = 10'($urandom);
        {id_rs_data, id_rt_data, id_pc4} = {$urandom, $urandom, $urandom};
        {id_imm, id_rs, id_rt, id_rd} = 31'($urandom);

        z.name = "reset1"; step(rnd, 1'b0, 1'b0, 1'b1, z);
        z.name = "reset2"; step(rnd, 1'b0, 1'b0, 1'b1, z);
        step(r_pass, 1'b0, 1'b0, 1'b0, ex_load("pass", 1'b0, r_pass, 32'hFFFF8000));
        step(lw8,    1'b0, 1'b0, 1'b0, ex_load("lw8", 1'b0, lw8, 32'h00000010));
        step(add8,   1'b0, 1'b0, 1'b0, ex_bubble("hazard", 1'b1));
        step(add8,   1'b0, 1'b0, 1'b0, ex_load("replay", 1'b0, add8, 32'h00005020));
        step(lw0,    1'b0, 1'b0, 1'b0, ex_load("lw_rt0", 1'b0, lw0, 32'hFFFFFFFC));
        step(r_rs0,  1'b0, 1'b0, 1'b0, ex_load("rs0_nohaz", 1'b0, r_rs0, 32'h00003820));
        step(lw8,    1'b0, 1'b0, 1'b0, ex_load("lw8b", 1'b0, lw8, 32'h00000010));
        step(addi8,  1'b0, 1'b0, 1'b0, ex_load("addi_nohaz", 1'b0, addi8, 32'h00000007));
        step(lw8,    1'b0, 1'b0, 1'b0, ex_load("lw8c", 1'b0, lw8, 32'h00000010));
        step(add8,   1'b1, 1'b0, 1'b0, ex_bubble("flush_haz", 1'b0));
        step(lw8,    1'b0, 1'b0, 1'b0, ex_load("lw8d", 1'b0, lw8, 32'h00000010));
        step(add8,   1'b0, 1'b1, 1'b0, ex_load("hold1", 1'b1, lw8, 32'h00000010));
        step(r_a,    1'b0, 1'b1, 1'b0, ex_load("hold2", 1'b1, lw8, 32'h00000010));
        step(r_b,    1'b0, 1'b1, 1'b0, ex_load("hold3", 1'b1, lw8, 32'h00000010));
        step(r_c,    1'b0, 1'b0, 1'b0, ex_load("release", 1'b0, r_c, 32'hFFFFFFFF));
        step(lw8,    1'b0, 1'b0, 1'b0, ex_load("lw8e", 1'b0, lw8, 32'h00000010));
        z.name = "reset_mid"; z.stall = 1'b1;
        step(add8,   1'b0, 1'b0, 1'b1, z);
        step(add8,   1'b0, 1'b0, 1'b0, ex_load("post_reset", 1'b0, add8, 32'h00005020));
        step(idle,   1'b0, 1'b0, 1'b0, ex_bubble("idle", 1'b0));
        step(lw8,    1'b0, 1'b0, 1'b0, ex_load("lw8f", 1'b0, lw8, 32'h00000010));
        step(lw_rs8, 1'b0, 1'b0, 1'b0, ex_bubble("b2b_haz1", 1'b1));
        step(lw_rs8, 1'b0, 1'b0, 1'b0, ex_load("b2b_load", 1'b0, lw_rs8, 32'h00000004));
        step(lw_rs8, 1'b0, 1'b0, 1'b0, ex_bubble("b2b_haz2", 1'b1));
        step(idle,   1'b0, 1'b0, 1'b0, ex_bubble("idle2", 1'b0));

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        repeat (2) @(posedge clk);
        check("scoreboard drained", 256'(exp_q.size()), 256'(0));
`ifdef BUBBLE_CNT_EN
        // Bubbles since the mid-run reset: the two back-to-back load hazards.
        check("bubble_cnt", 256'(bubble_cnt), 256'(16'd2));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS pipeline; sits directly downstream of the registered control unit and the register file.
- Captures the decoded control bundle, operands, sign-extended immediate and register addresses into the ID/EX register for the EX stage.
- Detects load-use hazards, requests an ID stall, and inserts bubbles on hazard or branch flush.

Parameters:
DATA_W, 32, operand/immediate/PC width
REG_AW, 5, register address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction this cycle
id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  control-unit outputs, aligned with ID data
id_aluop  in  2  control-unit ALUop
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  16  instruction[15:0]
id_rs, id_rt, id_rd  in  REG_AW  instruction register fields
id_pc4  in  DATA_W  PC+4 of the ID instruction
flush  in  1  branch taken in MEM; kill the ID instruction
ex_hold  in  1  downstream stall; freeze ID/EX
stall_id  out  1  combinational; hold PC and IF/ID
ex_valid  out  1  ID/EX holds a real instruction
ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  registered control
ex_aluop  out  2  registered ALUop
ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  DATA_W  registered operands; ex_imm is sign-extended
ex_rs, ex_rt, ex_rd  out  REG_AW  registered register addresses

Behaviour:
- Reset: all ex_* outputs 0; ex_aluop 2'b00; ex_valid 0.
- Latency: 1 cycle, ID to EX.
- Load-use detect:
  - hazard = id_valid & ex_valid & ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | ((ex_rt == id_rt) & (!id_alusrc | id_memwrite | id_branch))).
  - stall_id = (hazard | ex_hold) & !flush.
- Per-edge update, priority: reset > flush > ex_hold > hazard > load.
  - flush: bubble.
  - ex_hold: all ID/EX contents unchanged.
  - hazard: bubble. The ID instruction is held upstream and is re-presented next cycle.
  - load: capture all id_* fields; ex_valid <= id_valid.
- Bubble definition: ex_valid=0 and all control outputs 0. Data and address fields are don't-care and hold their previous values.
- !id_valid with no other condition: loads a bubble.
- Hazard stall lasts exactly 1 cycle, because the bubble clears ex_memread. Back-to-back loads to the same rt stall each time.
- Immediate: ex_imm = {{(DATA_W-16){id_imm[15]}}, id_imm}.
- Reset mid-stall: outputs return to reset values; stall_id drops the next cycle.

Optional Feature:
BUBBLE_CNT_EN:
- Defined: adds output bubble_cnt [15:0].
  - Increments on each edge where a hazard or flush bubble is inserted.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: no port, no counter logic.

Decomposition:
- mips_pkg holds:
  - opcode constants: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100
  - ALUop encodings: ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10
  - packed struct ctrl_t bundling the 8 control fields
  - localparam CTRL_NOP = all-zero ctrl_t
- One sub-module, load_use_detect: purely combinational hazard compare. The stage instantiates it.

Test Plan:
- Reset: assert reset 2 cycles with random id_* inputs -> all ex_* = 0, stall_id = 0.
- Pass-through: id_valid=1, R-type control (regdst=1, aluop=10, regwrite=1), rs_data=32'h5, imm=16'h8000 -> next cycle ex_valid=1, ex_rs_data=32'h5, ex_imm=32'hFFFF8000.
- Load-use hazard:
  - Stimulus: lw with rt=8 loaded; next ID is add rs=8.
  - Required: stall_id=1 for 1 cycle; next edge ex_valid=0 with all control 0; following edge the add is captured.
- No false hazards:
  - lw rt=0 followed by rs=0 -> stall_id=0.
  - lw rt=8 followed by addi rt=8 (alusrc=1, rs=3) -> stall_id=0.
- Flush over hazard: hazard condition and flush=1 same cycle -> stall_id=0, bubble loaded. With BUBBLE_CNT_EN, bubble_cnt increments by 1.
- Hold: ex_hold=1 for 3 cycles while id_* changes -> ex_* constant and stall_id=1 throughout; release -> pending ID instruction captured.
